// File: rtl/div_seq_if.sv
// Divide request/response bundle between the control unit and the divider.
//   master (control unit): drives start, dividend, divisor
//   slave  (divider)     : drives busy, done, div_zero, quot, rem
interface div_seq_if #(
    parameter int unsigned DATA_W = 32
);
    logic              start;
    logic [DATA_W-1:0] dividend;
    logic [DATA_W-1:0] divisor;
    logic              busy;
    logic              done;
    logic              div_zero;
    logic [DATA_W-1:0] quot;
    logic [DATA_W-1:0] rem;

    modport master (
        output start, dividend, divisor,
        input  busy, done, div_zero, quot, rem
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, div_zero, quot, rem
    );
endinterface

// File: rtl/div_seq.sv
// Sequential 32-bit signed restoring divider (MIPS DIV semantics).
// One quotient bit per cycle; 34 cycles from accepted start to done.
// Ports:
//   clock    - system clock, rising edge
//   reset    - synchronous active-low reset
//   bus      - div_seq_if.slave: start/dividend/divisor in,
//              busy/done/div_zero/quot(Lo)/rem(Hi) out, all registered
module div_seq (
    input  logic      clock,
    input  logic      reset,
    div_seq_if.slave  bus
);
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned PREM_W    = DATA_W + 1;
    localparam int unsigned CNT_W     = 6;
    localparam int unsigned LAST_ITER = DATA_W - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [PREM_W-1:0]   prem_q, prem_d;
    logic [DATA_W-1:0]   qsh_q, qsh_d;
    logic [DATA_W-1:0]   dvsr_q, dvsr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                sgn_dd_q, sgn_dd_d;
    logic                sgn_dv_q, sgn_dv_d;
    logic                zero_q, zero_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                div_zero_q, div_zero_d;
    logic [DATA_W-1:0]   quot_q, quot_d;
    logic [DATA_W-1:0]   rem_q, rem_d;

    logic [PREM_W-1:0]   shifted;
    logic [PREM_W-1:0]   trial;

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            prem_q     <= '0;
            qsh_q      <= '0;
            dvsr_q     <= '0;
            cnt_q      <= '0;
            sgn_dd_q   <= 1'b0;
            sgn_dv_q   <= 1'b0;
            zero_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            quot_q     <= '0;
            rem_q      <= '0;
        end else begin
            state_q    <= state_d;
            prem_q     <= prem_d;
            qsh_q      <= qsh_d;
            dvsr_q     <= dvsr_d;
            cnt_q      <= cnt_d;
            sgn_dd_q   <= sgn_dd_d;
            sgn_dv_q   <= sgn_dv_d;
            zero_q     <= zero_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
        end
    end

    // Next-state, datapath and registered-output logic
    always_comb begin
        state_d    = state_q;
        prem_d     = prem_q;
        qsh_d      = qsh_q;
        dvsr_d     = dvsr_q;
        cnt_d      = cnt_q;
        sgn_dd_d   = sgn_dd_q;
        sgn_dv_d   = sgn_dv_q;
        zero_d     = zero_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        div_zero_d = 1'b0;
        quot_d     = quot_q;
        rem_d      = rem_q;

        // Restoring step: partial remainder stays below 2^32, so bit 32
        // of the trial difference is its sign.
        shifted = {prem_q[DATA_W-1:0], qsh_q[DATA_W-1]};
        trial   = PREM_W'(shifted - {1'b0, dvsr_q});

        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (bus.start) begin
                    busy_d = 1'b1;
                    if (bus.divisor == '0) begin
                        zero_d     = 1'b1;
                        done_d     = 1'b1;
                        div_zero_d = 1'b1;
                        state_d    = DONE;
                    end else begin
                        // Negating 0x80000000 yields 0x80000000, which is
                        // the correct magnitude when read as unsigned.
                        qsh_d    = bus.dividend[DATA_W-1] ? DATA_W'(-bus.dividend)
                                                          : bus.dividend;
                        dvsr_d   = bus.divisor[DATA_W-1]  ? DATA_W'(-bus.divisor)
                                                          : bus.divisor;
                        prem_d   = '0;
                        cnt_d    = '0;
                        sgn_dd_d = bus.dividend[DATA_W-1];
                        sgn_dv_d = bus.divisor[DATA_W-1];
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                busy_d = 1'b1;
                if (!trial[PREM_W-1]) begin
                    prem_d = trial;
                    qsh_d  = {qsh_q[DATA_W-2:0], 1'b1};
                end else begin
                    prem_d = shifted;
                    qsh_d  = {qsh_q[DATA_W-2:0], 1'b0};
                end
                cnt_d = CNT_W'(cnt_q + CNT_W'(1));
                if (cnt_q == CNT_W'(LAST_ITER)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                busy_d  = 1'b1;
                quot_d  = (sgn_dd_q ^ sgn_dv_q) ? DATA_W'(-qsh_q) : qsh_q;
                rem_d   = sgn_dd_q ? DATA_W'(-prem_q[DATA_W-1:0])
                                   : prem_q[DATA_W-1:0];
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                busy_d  = 1'b0;
                zero_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;
    assign bus.quot     = quot_q;
    assign bus.rem      = rem_q;
endmodule

// File: doc/div_seq.md
# div_seq

Sequential 32-bit signed divider that answers the multi-cycle CPU's divide requests. The control unit raises a one-cycle start with operands from registers A and B. The block computes quotient and remainder over 34 cycles and signals completion. The Hi/Lo mux and registers then capture the result (Lo = quotient, Hi = remainder). It also reports divide-by-zero so the control unit can take the exception path.

## Interface
- DATA_W, 32, operand and result width; only 32 is supported.
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low reset; sampled on rising edge of clock.
- start  in  1  one-cycle divide request from the control unit (DivCtrl); honoured only in IDLE.
- dividend  in  32  signed dividend (register A); sampled on the start cycle only.
- divisor  in  32  signed divisor (register B); sampled on the start cycle only.
- busy  out  1  high from the cycle after an accepted start until done; reset 0.
- done  out  1  one-cycle pulse when a division finishes or is rejected; reset 0.
- div_zero  out  1  one-cycle pulse, coincident with done, when divisor was 0; reset 0.
- quot  out  32  quotient, to Lo mux; registered; reset 0.
- rem  out  32  remainder, to Hi mux; registered; reset 0.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1, divisor!=0:
  - latch |dividend| into the quotient shift register and |divisor| into the divisor register;
  - clear the partial remainder (33 bits) and the iteration counter (6 bits);
  - latch the sign bits; go to CALC.
- IDLE, start=1, divisor==0:
  - go to DONE with the zero flag set;
  - quot/rem keep their previous values.
- CALC, one restoring iteration per cycle:
  - shift {rem, quot} left 1;
  - trial = rem - divisor;
  - if trial is non-negative, rem=trial and quot LSB=1, else quot LSB=0;
  - after 32 iterations (counter==31 on the cycle it advances), go to FIX.
- FIX, sign correction and output load:
  - quot = negated if the dividend and divisor signs differ;
  - rem = negated if the dividend was negative;
  - load the quot/rem outputs; go to DONE.
- DONE: done=1 (div_zero=1 if the zero flag is set); clear the zero flag; go to IDLE.
- Semantics match MIPS DIV:
  - quotient truncates toward zero; remainder takes the dividend's sign;
  - |rem| < |divisor|; dividend = quot*divisor + rem (mod 2^32).
- Overflow case 0x80000000 / 0xFFFFFFFF gives quot=0x80000000, rem=0. This is wrap-around with no flag; the absolute value of 0x80000000 is handled as unsigned 0x80000000.
- start outside IDLE is ignored: operands are not resampled and no second done is produced.
- Reset low on any edge:
  - state goes to IDLE;
  - busy, done, div_zero, quot, rem and the internal registers all go to 0;
  - an in-flight division is abandoned with no done pulse.
- quot/rem hold their value from DONE until the next FIX. The CPU may capture them on or after the done cycle.

## Timing
- Cycle 0: start accepted in IDLE.
- Cycles 1-32: CALC, busy=1.
- Cycle 33: FIX, busy=1.
- Cycle 34: DONE, done=1, busy=1, quot/rem valid.
- Cycle 35: IDLE, busy=0; a new start is accepted this cycle.
- Divide by zero:
  - cycle 1 is DONE with done=1, div_zero=1, busy=1;
  - cycle 2 is IDLE.
- done and div_zero are never high for more than one consecutive cycle.
- Back-to-back: start in the cycle done is high is ignored; the earliest next accept is the cycle after done.

## Test plan
- 7 / 2, start at cycle 0 -> done at cycle 34 with quot=0x00000003, rem=0x00000001; busy high cycles 1-34.
- -7 / 2 and 7 / -2:
  - -7 / 2 -> quot=0xFFFFFFFD, rem=0xFFFFFFFF;
  - 7 / -2 -> quot=0xFFFFFFFD, rem=0x00000001.
- Preload quot=3/rem=1, then 5 / 0 -> cycle 1 done=1 and div_zero=1; quot/rem stay 3/1; cycle 2 busy=0.
- 0x80000000 / 0xFFFFFFFF -> quot=0x80000000, rem=0; -1 / 0x80000000 -> quot=0, rem=0xFFFFFFFF.
- Start at cycle 0, second start with other operands at cycle 10 -> single done at cycle 34 with first-operand result.
- Start at cycle 0, reset low at cycle 12 -> cycle 13: all outputs 0, IDLE; no done ever appears; a fresh start of 100 / 7 then gives quot=14, rem=2 after 34 cycles.
